prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 146 ++++++++++++++
 tb/tb_prog_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a word count, 18-bit words and an XOR checksum,
// writes the words to program memory and holds the MCU in reset while loading.
//
// state  | meaning
// IDLE   | waiting for START, MCU released
// CNT_HI | expecting word-count high byte (bits [2:0] used)
// CNT_LO | expecting word-count low byte, range-checked on acceptance
// B2     | expecting word byte 2 (bits [1:0] used)
// B1     | expecting word byte 1
// B0     | expecting word byte 0
// WRITE  | one-cycle program-memory write strobe
// CHK    | expecting checksum byte
// DONE_S | load completed, DONE held
// ERR_S  | load failed (range, checksum or timeout), ERR held
module prog_loader #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic [9:0]  WR_ADDR,
    output logic [17:0] WR_DATA,
    output logic        WR_EN,
    output logic        CPU_HOLD,
    output logic        DONE,
    output logic        ERR
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, CNT_HI, CNT_LO, B2, B1, B0, WRITE, CHK, DONE_S, ERR_S
    } state_t;

    state_t         state, nxt;
    logic [9:0]     addr;
    logic [9:0]     last_addr;
    logic [2:0]     cnt_hi;
    logic [7:0]     csum;
    logic [17:0]    data_reg;
    logic [TW-1:0]  timer;

    logic           rx_ready;
    logic           accept;
    logic           start_ok;
    logic           timeout;
    logic [10:0]    n_in;

    always_comb begin
        rx_ready = (state inside {CNT_HI, CNT_LO, B2, B1, B0, CHK});
        accept   = rx_ready && RX_VALID;
        start_ok = START && (state inside {IDLE, DONE_S, ERR_S});
        timeout  = rx_ready && (timer == TW'(TIMEOUT_CYC - 1));
        n_in     = {cnt_hi, RX_DATA};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= nxt;
    end

    // Timeout is evaluated before byte acceptance so it wins a same-cycle tie.
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE_S, ERR_S: if (start_ok) nxt = CNT_HI;
            CNT_HI: begin
                if (timeout)     nxt = ERR_S;
                else if (accept) nxt = CNT_LO;
            end
            CNT_LO: begin
                if (timeout) nxt = ERR_S;
                else if (accept) begin
                    if (n_in == 11'd0 || n_in > 11'd1024) nxt = ERR_S;
                    else                                    nxt = B2;
                end
            end
            B2: begin
                if (timeout)     nxt = ERR_S;
                else if (accept) nxt = B1;
            end
            B1: begin
                if (timeout)     nxt = ERR_S;
                else if (accept) nxt = B0;
            end
            B0: begin
                if (timeout)     nxt = ERR_S;
                else if (accept) nxt = WRITE;
            end
            WRITE: nxt = (addr == last_addr) ? CHK : B2;
            CHK: begin
                if (timeout)     nxt = ERR_S;
                else if (accept) nxt = (RX_DATA == csum) ? DONE_S : ERR_S;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr      <= '0;
            last_addr <= '0;
            cnt_hi    <= '0;
            csum      <= '0;
            data_reg  <= '0;
            timer     <= '0;
        end else if (start_ok) begin
            addr  <= '0;
            csum  <= '0;
            timer <= '0;
        end else begin
            if (accept)        timer <= '0;
            else if (rx_ready) timer <= timer + 1'b1;

            if (accept && state != CHK) csum <= csum ^ RX_DATA;

            if (accept) begin
                case (state)
                    CNT_HI: cnt_hi <= RX_DATA[2:0];
                    CNT_LO: last_addr <= 10'(n_in - 11'd1);
                    B2:     data_reg[17:16] <= RX_DATA[1:0];
                    B1:     data_reg[15:8]  <= RX_DATA;
                    B0:     data_reg[7:0]   <= RX_DATA;
                    default: ;
                endcase
            end

            // 10-bit wrap after word 1024 is harmless: CHK follows, never another write.
            if (state == WRITE) addr <= addr + 10'd1;
        end
    end

    always_comb begin
        RX_READY = rx_ready;
        WR_EN    = (state == WRITE);
        WR_ADDR  = addr;
        WR_DATA  = data_reg;
        CPU_HOLD = !(state inside {IDLE, DONE_S, ERR_S});
        DONE     = (state == DONE_S);
        ERR      = (state == ERR_S);
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of short loads plus hand-written sequences
// for the full 1024-word load, inter-byte timeout and mid-load reset.
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        RX_READY;
    logic [9:0]  WR_ADDR;
    logic [17:0] WR_DATA;
    logic        WR_EN;
    logic        CPU_HOLD;
    logic        DONE;
    logic        ERR;

    always #5 CLK = ~CLK;

    prog_loader #(.TIMEOUT_CYC(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .WR_EN    (WR_EN),
        .CPU_HOLD (CPU_HOLD),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0]  wa_q[$];
    logic [17:0] wd_q[$];

    always @(negedge CLK) begin
        if (WR_EN) begin
            wa_q.push_back(WR_ADDR);
            wd_q.push_back(WR_DATA);
        end
    end

    typedef struct {
        string           name;
        int              nb;
        logic [0:8][7:0] b;
        int              nw;
        logic [17:0]     w0;
        logic [17:0]     w1;
        logic            done;
        logic            err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        k = 0;
        @(negedge CLK);
        while (!RX_READY && k < 40) begin
            @(negedge CLK);
            k++;
        end
        if (!RX_READY) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_ready_wait: got 0 want 1 (byte 0x%0h)", b);
            RX_VALID = 1'b0;
        end else begin
            @(posedge CLK);
            #1 RX_VALID = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(posedge CLK);
        #1 START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [9:0]  a0, a1;
        logic [17:0] d0, d1;
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        check({v.name, "_hold_busy"}, 32'(CPU_HOLD), 32'd1);
        check({v.name, "_flags_clear"}, {30'd0, DONE, ERR}, 32'd0);
        for (int j = 0; j < v.nb; j++) send_byte(v.b[j]);
        settle();
        a0 = (wa_q.size() > 0) ? wa_q[0] : 'x;
        d0 = (wd_q.size() > 0) ? wd_q[0] : 'x;
        a1 = (wa_q.size() > 1) ? wa_q[1] : 'x;
        d1 = (wd_q.size() > 1) ? wd_q[1] : 'x;
        check({v.name, "_nwrites"}, 32'(wd_q.size()), 32'(v.nw));
        if (v.nw > 0) begin
            check({v.name, "_w0"}, {12'd0, a0, 10'd0} | 32'(d0), 32'(v.w0));
        end
        if (v.nw > 1) begin
            check({v.name, "_w1"}, {12'd1, a1, 10'd0} ^ {12'd1, 10'd1, 10'd0} ^ 32'(d1), 32'(v.w1));
        end
        check({v.name, "_done"}, 32'(DONE), 32'(v.done));
        check({v.name, "_err"}, 32'(ERR), 32'(v.err));
        check({v.name, "_hold_rel"}, 32'(CPU_HOLD), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cs;
        logic [9:0]  iv;
        logic [7:0]  b2, b1, b0;
        int          bad_a, bad_d, n;
        logic [17:0] exp_w;

        // Checksum of 00 02 01 23 45 02 AB CD is 0x01.
        vecs[0] = '{"good_n2",   9, {8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'h01},
                    2, 18'h12345, 18'h2ABCD, 1'b1, 1'b0};
        vecs[1] = '{"bad_csum",  9, {8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'h03},
                    2, 18'h12345, 18'h2ABCD, 1'b0, 1'b1};
        vecs[2] = '{"n1025",     2, {8'h04, 8'h01, 56'h0}, 0, 18'h0, 18'h0, 1'b0, 1'b1};
        vecs[3] = '{"n0",        2, {8'h00, 8'h00, 56'h0}, 0, 18'h0, 18'h0, 1'b0, 1'b1};
        vecs[4] = '{"b2_hibits", 6, {8'h00, 8'h01, 8'hFE, 8'h12, 8'h34, 8'hD9, 24'h0},
                    1, 18'h21234, 18'h0, 1'b1, 1'b0};
        vecs[5] = '{"cnthi_hibits", 6, {8'hF8, 8'h01, 8'h00, 8'h00, 8'h07, 8'hFE, 24'h0},
                    1, 18'h00007, 18'h0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_rx_ready", 32'(RX_READY), 32'd0);
        check("rst_wr", {3'd0, WR_EN, WR_ADDR, WR_DATA}, 32'd0);
        check("rst_flags", {29'd0, CPU_HOLD, DONE, ERR}, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        settle();
        check("idle_no_start", {29'd0, CPU_HOLD, RX_READY, WR_EN}, 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Full 1024-word load; a START mid-load must be ignored.
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        cs = 8'h04 ^ 8'h00;
        send_byte(8'h04);
        send_byte(8'h00);
        for (int i = 0; i < 1024; i++) begin
            iv = 10'(i);
            b2 = {6'b101010, iv[9:8]};
            b1 = iv[7:0];
            b0 = ~iv[7:0] ^ 8'h5A;
            cs = cs ^ b2 ^ b1 ^ b0;
            if (i == 5) START = 1'b1;
            send_byte(b2);
            START = 1'b0;
            send_byte(b1);
            send_byte(b0);
        end
        send_byte(cs);
        settle();
        bad_a = 0;
        bad_d = 0;
        for (int k = 0; k < wd_q.size(); k++) begin
            iv = 10'(k);
            exp_w = {iv[9:8], iv[7:0], ~iv[7:0] ^ 8'h5A};
            if (wa_q[k] !== iv) bad_a++;
            if (wd_q[k] !== exp_w) bad_d++;
        end
        check("n1024_nwrites", 32'(wd_q.size()), 32'd1024);
        check("n1024_addr_seq", 32'(bad_a), 32'd0);
        check("n1024_data", 32'(bad_d), 32'd0);
        check("n1024_done", {30'd0, DONE, ERR}, 32'd2);
        check("n1024_hold", 32'(CPU_HOLD), 32'd0);
        repeat (20) @(posedge CLK);
        #1;
        check("n1024_no_wrap_write", 32'(wd_q.size()), 32'd1024);

        // Inter-byte timeout in B0 of word 0
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h23);
        n = 0;
        while (!ERR && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd16);
        check("tmo_nwrites", 32'(wd_q.size()), 32'd0);
        check("tmo_flags", {29'd0, CPU_HOLD, DONE, ERR}, 32'd1);

        // Reset pulse during B1 of word 3, then a clean load
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h03);
            send_byte(8'(k));
            send_byte(8'h10 + 8'(k));
        end
        send_byte(8'h03);
        RX_DATA  = 8'h77;
        RX_VALID = 1'b1;
        RST      = 1'b1;
        #2;
        check("arst_rx_ready", 32'(RX_READY), 32'd0);
        check("arst_wr", {3'd0, WR_EN, WR_ADDR, WR_DATA}, 32'd0);
        check("arst_flags", {29'd0, CPU_HOLD, DONE, ERR}, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("arst_stays_idle", {29'd0, CPU_HOLD, RX_READY, ERR}, 32'd0);
        check("arst_nwrites", 32'(wd_q.size()), 32'd3);
        RX_VALID = 1'b0;
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
